// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// the load result-source code and the MUL/DIV occupancy FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Forwarding comparator for one Execute-stage operand; the nearer M producer
// wins over W, and x0 is never forwarded because it always reads as zero.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output fwd_sel_e          sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      sel = FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: operand forwarding, load-use stall, redirect flush
// and a MUL/DIV occupancy FSM that freezes F/D/E, plus a saturating stall counter.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic [1:0]        PCSrcE,
  input  logic              MulDivStartE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MulDivBusy,
  output logic [CNT_W-1:0]  StallCount
);

  localparam int              MD_CW    = $clog2(MULDIV_LAT + 1);
  localparam bit              LAT_GT1  = (MULDIV_LAT > 1);
  // Start cycle is the first occupancy cycle, so BUSY only needs LAT-2 more stall cycles.
  localparam logic [MD_CW-1:0] CNT_INIT = MD_CW'((MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0);

  md_state_e        state, state_nx;
  logic [MD_CW-1:0] cnt, cnt_nx;
  fwd_sel_e         fwd_a, fwd_b;
  logic             md_stall, load_use, redirect;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e(Rs1E), .rd_m(RdM), .rd_w(RdW),
    .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .sel(fwd_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e(Rs2E), .rd_m(RdM), .rd_w(RdW),
    .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .sel(fwd_b)
  );

  assign md_stall = ((state == MD_IDLE) && MulDivStartE && LAT_GT1) ||
                    ((state == MD_BUSY) && (cnt != '0));
  assign load_use = (ResultSrcE == RESULTSRC_LOAD) && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign redirect = (PCSrcE != 2'b00);
  assign MulDivBusy = (state == MD_BUSY);

  // Priority: reset > MUL/DIV freeze (op must survive in E) > redirect > load-use.
  always_comb begin
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    if (rst) begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushM    = 1'b1;
    end else if (md_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (redirect) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      MD_IDLE: begin
        if (MulDivStartE && LAT_GT1) begin
          state_nx = MD_BUSY;
          cnt_nx   = CNT_INIT;
        end
      end
      MD_BUSY: begin
        if (cnt != '0) begin
          cnt_nx = cnt - MD_CW'(1);
        end else begin
          state_nx = MD_IDLE;
        end
      end
      default: state_nx = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MD_IDLE;
      cnt        <= '0;
      StallCount <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (StallF) begin
        StallCount <= sat_inc(StallCount);
      end
    end
  end

  // Only one instruction sits in E, so a MUL/DIV start cannot also be a taken redirect.
  a_start_vs_redirect : assert property (@(posedge clk) disable iff (rst)
    !(MulDivStartE && (PCSrcE != 2'b00)));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl: a default instance and a
// LAT=1 / 4-bit-counter instance share the same stimulus.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, MulDivStartE;
  logic [1:0] ResultSrcE, PCSrcE;

  logic [1:0]  fa0, fb0, fa1, fb1;
  logic        sf0, sd0, se0, fd0, fe0, fm0, busy0;
  logic        sf1, sd1, se1, fd1, fe1, fm1, busy1;
  logic [31:0] cnt0;
  logic [3:0]  cnt1;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5), .MULDIV_LAT(4), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulDivStartE(MulDivStartE),
    .ForwardAE(fa0), .ForwardBE(fb0), .StallF(sf0), .StallD(sd0), .StallE(se0),
    .FlushD(fd0), .FlushE(fe0), .FlushM(fm0), .MulDivBusy(busy0), .StallCount(cnt0)
  );

  pipeline_hazard_ctrl #(.REG_AW(5), .MULDIV_LAT(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulDivStartE(MulDivStartE),
    .ForwardAE(fa1), .ForwardBE(fb1), .StallF(sf1), .StallD(sd1), .StallE(se1),
    .FlushD(fd1), .FlushE(fe1), .FlushM(fm1), .MulDivBusy(busy1), .StallCount(cnt1)
  );

  // Packed view: {fa[42:41], fb[40:39], sf, sd, se, fd, fe, fm, busy, cnt[31:0]}
  logic [42:0] obs0, obs1;
  assign obs0 = {fa0, fb0, sf0, sd0, se0, fd0, fe0, fm0, busy0, cnt0};
  assign obs1 = {fa1, fb1, sf1, sd1, se1, fd1, fe1, fm1, busy1, 28'd0, cnt1};

  localparam logic [42:0] M_ALL     = {43{1'b1}};
  localparam logic [42:0] M_NOCNT   = {11'h7FF, 32'h0};
  localparam logic [42:0] M_NOBUSY  = {11'h7FE, 32'hFFFF_FFFF};
  localparam logic [42:0] M_CTL     = {4'h0, 7'h7F, 32'h0};
  localparam logic [42:0] M_SF_CNT  = {4'h0, 7'h40, 32'hF};

  typedef struct packed {
    logic        which;
    logic [42:0] val;
    logic [42:0] mask;
  } exp_t;

  exp_t        q[$];
  string       tq[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_cnt;

  // Pushes a default-instance expectation; the counter field comes from the bench's own count.
  task automatic step0(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [6:0] ctl, input logic [42:0] mask);
    exp_t e;
    e.which = 1'b0;
    e.val   = {fa, fb, ctl, exp_cnt};
    e.mask  = mask;
    q.push_back(e);
    tq.push_back(tag);
    if (ctl[6]) exp_cnt = (exp_cnt == 32'hFFFF_FFFF) ? exp_cnt : exp_cnt + 32'd1;
  endtask

  task automatic step1(input string tag, input logic [6:0] ctl, input logic [3:0] c,
                       input logic [42:0] mask);
    exp_t e;
    e.which = 1'b1;
    e.val   = {4'b0000, ctl, 28'd0, c};
    e.mask  = mask;
    q.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic settle_check();
    exp_t        e;
    string       tag;
    logic [42:0] obs;
    #2;
    while (q.size() > 0) begin
      e   = q.pop_front();
      tag = tq.pop_front();
      obs = e.which ? obs1 : obs0;
      checks++;
      assert ((obs & e.mask) === (e.val & e.mask))
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs & e.mask, e.val & e.mask);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 2'b00; PCSrcE = 2'b00; MulDivStartE = 1'b0;
  endtask

  initial begin
    exp_cnt = 32'd0;
    idle_inputs();
    // Reset, with a live forwarding match that must be masked to RF
    rst = 1'b1; RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
    step0("rst_first", 2'b00, 2'b00, 7'b0001110, M_NOCNT & M_NOBUSY);
    settle_check();
    exp_cnt = 32'd0;
    step0("rst_state", 2'b00, 2'b00, 7'b0001110, M_ALL);
    settle_check();
    rst = 1'b0;

    // Forwarding
    RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5;
    step0("fwd_m_over_w", 2'b10, 2'b10, 7'b0000000, M_ALL);
    settle_check();
    RdM = 5'd0;
    step0("fwd_rdm0_w", 2'b01, 2'b01, 7'b0000000, M_ALL);
    settle_check();
    RdW = 5'd0;
    step0("fwd_x0_none", 2'b00, 2'b00, 7'b0000000, M_ALL);
    settle_check();
    RegWriteM = 1'b0; RdM = 5'd5; RdW = 5'd7; Rs2E = 5'd7; Rs1E = 5'd5;
    step0("fwd_nowrite_m", 2'b00, 2'b01, 7'b0000000, M_ALL);
    settle_check();
    RegWriteM = 1'b1; RdM = 5'd9; Rs1E = 5'd9; RegWriteW = 1'b0;
    step0("fwd_a_m_b_rf", 2'b10, 2'b00, 7'b0000000, M_ALL);
    settle_check();
    idle_inputs();

    // Load-use
    ResultSrcE = RESULTSRC_LOAD; RdE = 5'd6; Rs2D = 5'd6;
    step0("load_use", 2'b00, 2'b00, 7'b1100100, M_ALL);
    settle_check();
    RdE = 5'd0; Rs2D = 5'd0;
    step0("load_x0_nostall", 2'b00, 2'b00, 7'b0000000, M_ALL);
    settle_check();
    ResultSrcE = 2'b00; RdE = 5'd6; Rs1D = 5'd6;
    step0("alu_no_stall", 2'b00, 2'b00, 7'b0000000, M_ALL);
    settle_check();

    // Redirect, alone and over load-use
    idle_inputs();
    PCSrcE = 2'b10;
    step0("redirect", 2'b00, 2'b00, 7'b0001100, M_ALL);
    settle_check();
    PCSrcE = 2'b01; ResultSrcE = RESULTSRC_LOAD; RdE = 5'd6; Rs1D = 5'd6;
    step0("redirect_over_lu", 2'b00, 2'b00, 7'b0001100, M_ALL);
    settle_check();
    idle_inputs();

    // MUL/DIV, LAT=4 occupies E four cycles; LAT=1 never stalls
    MulDivStartE = 1'b1;
    step0("md_t0", 2'b00, 2'b00, 7'b1110010, M_ALL);
    step1("md1_t0", 7'b0000000, 4'd0, M_CTL);
    settle_check();
    MulDivStartE = 1'b0;
    step0("md_t1", 2'b00, 2'b00, 7'b1110011, M_ALL);
    step1("md1_t1", 7'b0000000, 4'd0, M_CTL);
    settle_check();
    step0("md_t2", 2'b00, 2'b00, 7'b1110011, M_ALL);
    settle_check();
    step0("md_t3_free", 2'b00, 2'b00, 7'b0000000, M_NOBUSY);
    settle_check();
    step0("md_t4_idle", 2'b00, 2'b00, 7'b0000000, M_ALL);
    settle_check();

    // Reset in the middle of BUSY
    MulDivStartE = 1'b1;
    step0("md2_t0", 2'b00, 2'b00, 7'b1110010, M_ALL);
    settle_check();
    MulDivStartE = 1'b0;
    step0("md2_t1", 2'b00, 2'b00, 7'b1110011, M_ALL);
    settle_check();
    rst = 1'b1;
    step0("md2_rst", 2'b00, 2'b00, 7'b0001111, M_ALL);
    settle_check();
    rst = 1'b0;
    exp_cnt = 32'd0;
    step0("md2_after_rst", 2'b00, 2'b00, 7'b0000000, M_ALL);
    settle_check();

    // Saturation of the 4-bit counter under a held load-use
    rst = 1'b1;
    settle_check();
    rst = 1'b0;
    exp_cnt = 32'd0;
    ResultSrcE = RESULTSRC_LOAD; RdE = 5'd6; Rs2D = 5'd6;
    for (int i = 0; i < 20; i++) begin
      step0("sat_lu0", 2'b00, 2'b00, 7'b1100100, M_ALL);
      step1("sat_cnt1", 7'b1000000, (i < 15) ? 4'(i) : 4'd15, M_SF_CNT);
      settle_check();
    end
    idle_inputs();
    step0("sat_end0", 2'b00, 2'b00, 7'b0000000, M_ALL);
    step1("sat_end1", 7'b0000000, 4'd15, M_SF_CNT);
    settle_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
